// File: rtl/controller_input_conditioner.sv
// rtl/controller_input_conditioner.sv - synchronise, debounce and latch events for game-controller pins
//
// Purpose:
//   Conditions the raw PMOD JD/JC controller pins before the MMIO read path.
//   Each button is synchronised through two flops, normalised to "1 = pressed",
//   debounced with its own counter, and exposed as a level vector. Sticky
//   press/release event bits record committed transitions until software
//   clears them through an MMIO write-to-clear strobe.
//
// Ports:
//   clk              in   system clock (25 MHz CPU/VGA clock)
//   reset            in   asynchronous, active-high reset
//   raw_btn          in   unsynchronised pin levels {JC[10:1], JD[10:1]}
//   clr_en           in   one-cycle write-to-clear strobe
//   clr_mask         in   event bits to clear when clr_en is high
//   btn_level        out  debounced state, 1 = pressed
//   press_pending    out  sticky unpressed->pressed events
//   release_pending  out  sticky pressed->unpressed events
//   any_press        out  OR of press_pending

module controller_input_conditioner #(
    parameter int NUM_BUTTONS     = 20,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] raw_btn,
    input  logic                   clr_en,
    input  logic [NUM_BUTTONS-1:0] clr_mask,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] press_pending,
    output logic [NUM_BUTTONS-1:0] release_pending,
    output logic                   any_press
);

    // Pin level of a button that is not being pressed.
    localparam logic                 IDLE_LEVEL = (ACTIVE_LOW != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] sync1_q;
    logic [NUM_BUTTONS-1:0] sync2_q;
    logic [NUM_BUTTONS-1:0] pressed;

    logic [NUM_BUTTONS-1:0] level_q;
    logic [NUM_BUTTONS-1:0] level_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_BUTTONS];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] commit;

    logic [NUM_BUTTONS-1:0] clr_vec;
    logic [NUM_BUTTONS-1:0] press_q;
    logic [NUM_BUTTONS-1:0] press_d;
    logic [NUM_BUTTONS-1:0] release_q;
    logic [NUM_BUTTONS-1:0] release_d;

    // Two-flop synchroniser. Resetting to the idle pin level keeps the
    // debouncer from seeing a phantom press right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= {NUM_BUTTONS{IDLE_LEVEL}};
            sync2_q <= {NUM_BUTTONS{IDLE_LEVEL}};
        end else begin
            sync1_q <= raw_btn;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = IDLE_LEVEL ? ~sync2_q : sync2_q;

    // Per-button debounce: the counter runs only while the synchronised level
    // differs from the committed one; any return to the committed level drops
    // the count, so only a level that persists DEBOUNCE_CYCLES cycles commits.
    always_comb begin
        level_d = level_q;
        commit  = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_d[i] = '0;
            if (pressed[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = pressed[i];
                    commit[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Event bits: the set term is OR-ed in after the clear so a commit that
    // coincides with a clear of the same bit is never lost.
    always_comb begin
        clr_vec   = clr_en ? clr_mask : '0;
        press_d   = (press_q & ~clr_vec) | (commit & pressed);
        release_d = (release_q & ~clr_vec) | (commit & ~pressed);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level       = level_q;
    assign press_pending   = press_q;
    assign release_pending = release_q;
    assign any_press       = |press_q;

endmodule

// File: tb/tb_controller_input_conditioner.sv
// tb/tb_controller_input_conditioner.sv - directed self-checking bench for controller_input_conditioner

module tb_controller_input_conditioner;

    localparam int NB = 20;

    logic          clk;
    logic          reset;
    logic [NB-1:0] raw_btn;
    logic          clr_en;
    logic [NB-1:0] clr_mask;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] press_pending;
    logic [NB-1:0] release_pending;
    logic          any_press;

    int n_tests;
    int n_fail;

    controller_input_conditioner #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (18),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .raw_btn         (raw_btn),
        .clr_en          (clr_en),
        .clr_mask        (clr_mask),
        .btn_level       (btn_level),
        .press_pending   (press_pending),
        .release_pending (release_pending),
        .any_press       (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and settle at the following falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        raw_btn  = 20'hFFFFF;
        clr_en   = 1'b0;
        clr_mask = '0;

        // 1: reset with all pins idle, then idle for 100 cycles
        tick(2);
        check("rst_level", btn_level, 20'h0);
        check("rst_press", press_pending, 20'h0);
        check("rst_release", release_pending, 20'h0);
        check("rst_any", NB'(any_press), 20'h0);
        reset = 1'b0;
        tick(100);
        check("idle_level", btn_level, 20'h0);
        check("idle_press", press_pending, 20'h0);
        check("idle_release", release_pending, 20'h0);

        // 2: press bit 0; commit on edge k+5, not k+4
        raw_btn[0] = 1'b0;
        tick(5);
        check("lat_k4_level", btn_level, 20'h0);
        check("lat_k4_press", press_pending, 20'h0);
        tick(1);
        check("lat_k5_level", btn_level, 20'h00001);
        check("lat_k5_press", press_pending, 20'h00001);
        check("lat_k5_any", NB'(any_press), 20'h1);

        // 3: 3-cycle glitch on bit 3 never commits
        raw_btn[3] = 1'b0;
        tick(3);
        raw_btn[3] = 1'b1;
        tick(10);
        check("glitch_level", btn_level, 20'h00001);
        check("glitch_press", press_pending, 20'h00001);

        // release bit 0 so a fresh press can be timed against a clear
        raw_btn[0] = 1'b1;
        tick(6);
        check("rel0_level", btn_level, 20'h0);
        check("rel0_release", release_pending, 20'h00001);
        check("rel0_press_kept", press_pending, 20'h00001);

        // 4: clear coinciding with a press commit: set wins
        raw_btn[0] = 1'b0;
        tick(5);
        clr_en   = 1'b1;
        clr_mask = 20'h00001;
        tick(1);
        clr_en   = 1'b0;
        check("setwins_level", btn_level, 20'h00001);
        check("setwins_press", press_pending, 20'h00001);
        check("setwins_release_cleared", release_pending, 20'h0);
        check("setwins_any", NB'(any_press), 20'h1);
        clr_mask = 20'hFFFFF;
        tick(1);
        check("clr_ignored", press_pending, 20'h00001);
        clr_en   = 1'b1;
        clr_mask = 20'h00001;
        tick(1);
        clr_en   = 1'b0;
        check("clr_press", press_pending, 20'h0);
        check("clr_any", NB'(any_press), 20'h0);

        // 5: JD[1] and JC[1] released together
        raw_btn[10] = 1'b0;
        tick(6);
        check("jc1_level", btn_level, 20'h00401);
        check("jc1_press", press_pending, 20'h00400);
        clr_en   = 1'b1;
        clr_mask = 20'hFFFFF;
        tick(1);
        clr_en   = 1'b0;
        check("clr_all", press_pending, 20'h0);
        raw_btn[0]  = 1'b1;
        raw_btn[10] = 1'b1;
        tick(5);
        check("dual_rel_k4", release_pending, 20'h0);
        tick(1);
        check("dual_rel_k5", release_pending, 20'h00401);
        check("dual_rel_level", btn_level, 20'h0);

        // 6: reset mid-debounce of bit 5 discards the partial count
        raw_btn[5] = 1'b0;
        tick(3);
        #2 reset = 1'b1;
        #1;
        check("midrst_release", release_pending, 20'h0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("midrst_k4_level", btn_level, 20'h0);
        check("midrst_k4_press", press_pending, 20'h0);
        tick(1);
        check("midrst_k5_level", btn_level, 20'h00020);
        check("midrst_k5_press", press_pending, 20'h00020);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
